// File: rtl/qeciphy_status_tracker_if.sv
// Event stream from the status tracker: one change record per valid/ready handshake.
// The tracker drives it through the master modport; the consumer uses slave.
interface qeciphy_status_tracker_if #(
    parameter int CH_W     = 1,
    parameter int STATUS_W = 4,
    parameter int ECODE_W  = 4,
    parameter int TIME_W   = 16
);
    logic                evt_valid_o;
    logic                evt_ready_i;
    logic [CH_W-1:0]     evt_ch_o;
    logic [STATUS_W-1:0] evt_status_o;
    logic [ECODE_W-1:0]  evt_ecode_o;
    logic [TIME_W-1:0]   evt_time_o;

    modport master (
        output evt_valid_o, evt_ch_o, evt_status_o, evt_ecode_o, evt_time_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o, evt_ch_o, evt_status_o, evt_ecode_o, evt_time_o,
        output evt_ready_i
    );
endinterface

// File: rtl/qeciphy_status_tracker.sv
// Multi-channel status/ecode change tracker: timestamped event FIFO, sticky first-error codes, saturating error count.
// Event latency 2 edges from input change; FIFO full holds the channel pending (no drop), re-change while pending coalesces.
// Define QECIPHY_STATUS_TRACKER_TIMESTAMP_EN to build the time counter; otherwise evt_time_o is tied to 0.
module qeciphy_status_tracker #(
    parameter int NUM_CH     = 2,
    parameter int STATUS_W   = 4,
    parameter int ECODE_W    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIME_W     = 16,
    parameter int CNT_W      = 16
) (
    input  logic                        aclk,
    input  logic                        arst_n,
    input  logic [NUM_CH*STATUS_W-1:0]  status_i,
    input  logic [NUM_CH*ECODE_W-1:0]   ecode_i,
    input  logic                        clr_i,
    qeciphy_status_tracker_if.master    evt,
    output logic                        overflow_o,
    output logic [NUM_CH-1:0]           err_sticky_o,
    output logic [NUM_CH*ECODE_W-1:0]   first_ecode_o,
    output logic [CNT_W-1:0]            num_errors_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EC_W = $clog2(NUM_CH + 1);

    typedef struct packed {
        logic [STATUS_W-1:0] status;
        logic [ECODE_W-1:0]  ecode;
`ifdef QECIPHY_STATUS_TRACKER_TIMESTAMP_EN
        logic [TIME_W-1:0]   tstamp;
`endif
    } snap_t;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        snap_t           s;
    } entry_t;

    logic [NUM_CH*STATUS_W-1:0] prev_status;
    logic [NUM_CH*ECODE_W-1:0]  prev_ecode;
    logic [NUM_CH-1:0]          chg, err_ev, pending, gnt_oh;
    snap_t                      snap  [NUM_CH];
    snap_t                      nsnap [NUM_CH];
    snap_t                      gnt_snap;
    logic [CH_W-1:0]            gnt_ch;
    logic [EC_W-1:0]            err_cnt;
    logic [CNT_W:0]             err_sum;
    entry_t                     mem [FIFO_DEPTH];
    logic [AW:0]                wr_ptr, rd_ptr;
    logic                       full, empty, push, pop;
    entry_t                     head;

`ifdef QECIPHY_STATUS_TRACKER_TIMESTAMP_EN
    logic [TIME_W-1:0] tcnt;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n)     tcnt <= '0;
        else if (clr_i)  tcnt <= '0;
        else             tcnt <= tcnt + TIME_W'(1);
    end
`endif

    always_comb begin
        chg      = '0;
        err_ev   = '0;
        gnt_ch   = '0;
        gnt_snap = '0;
        err_cnt  = '0;
        // Lowest set bit of pending wins arbitration.
        gnt_oh   = pending & (~pending + NUM_CH'(1));
        for (int c = 0; c < NUM_CH; c++) begin
            chg[c]    = (status_i[c*STATUS_W +: STATUS_W] != prev_status[c*STATUS_W +: STATUS_W]) ||
                        (ecode_i[c*ECODE_W +: ECODE_W] != prev_ecode[c*ECODE_W +: ECODE_W]);
            err_ev[c] = (prev_ecode[c*ECODE_W +: ECODE_W] == '0) && (ecode_i[c*ECODE_W +: ECODE_W] != '0);
            nsnap[c]        = '0;
            nsnap[c].status = status_i[c*STATUS_W +: STATUS_W];
            nsnap[c].ecode  = ecode_i[c*ECODE_W +: ECODE_W];
`ifdef QECIPHY_STATUS_TRACKER_TIMESTAMP_EN
            nsnap[c].tstamp = tcnt;
`endif
            if (gnt_oh[c]) begin
                gnt_ch   = CH_W'(c);
                gnt_snap = snap[c];
            end
            err_cnt = err_cnt + EC_W'(err_ev[c]);
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && evt.evt_ready_i;
    assign push    = (|pending) && (!full || pop);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign err_sum = {1'b0, num_errors_o} + (CNT_W+1)'(err_cnt);

    assign evt.evt_valid_o  = !empty;
    assign evt.evt_ch_o     = head.ch;
    assign evt.evt_status_o = head.s.status;
    assign evt.evt_ecode_o  = head.s.ecode;
`ifdef QECIPHY_STATUS_TRACKER_TIMESTAMP_EN
    assign evt.evt_time_o   = head.s.tstamp;
`else
    assign evt.evt_time_o   = TIME_W'(0);
`endif

    // prev always follows the inputs, including on clr edges, so a clear never fabricates events.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            prev_status <= '0;
            prev_ecode  <= '0;
            pending     <= '0;
            overflow_o  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) snap[c] <= '0;
        end else begin
            prev_status <= status_i;
            prev_ecode  <= ecode_i;
            if (clr_i) begin
                pending    <= '0;
                overflow_o <= 1'b0;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (chg[c]) begin
                        pending[c] <= 1'b1;
                        snap[c]    <= nsnap[c];
                        if (pending[c] && !(push && gnt_oh[c])) overflow_o <= 1'b1;
                    end else if (push && gnt_oh[c]) begin
                        pending[c] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= '{ch: gnt_ch, s: gnt_snap};
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            err_sticky_o  <= '0;
            first_ecode_o <= '0;
            num_errors_o  <= '0;
        end else if (clr_i) begin
            err_sticky_o  <= '0;
            first_ecode_o <= '0;
            num_errors_o  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (err_ev[c]) begin
                    err_sticky_o[c] <= 1'b1;
                    if (!err_sticky_o[c]) first_ecode_o[c*ECODE_W +: ECODE_W] <= ecode_i[c*ECODE_W +: ECODE_W];
                end
            end
            num_errors_o <= err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_qeciphy_status_tracker.sv
// Bench for qeciphy_status_tracker: directed scenarios plus random traffic, scored against a queue-based event model.
module tb_qeciphy_status_tracker;
    localparam int NUM_CH = 2;
    localparam int SW     = 4;
    localparam int EW     = 4;
    localparam int DEPTH  = 8;
    localparam int TW     = 16;
    localparam int CW     = 16;
    localparam int CHW    = 1;

    logic                   aclk   = 1'b0;
    logic                   arst_n = 1'b1;
    logic [NUM_CH*SW-1:0]   status_i = '0;
    logic [NUM_CH*EW-1:0]   ecode_i  = '0;
    logic                   clr_i    = 1'b0;
    logic                   ready    = 1'b1;
    logic                   overflow_o;
    logic [NUM_CH-1:0]      err_sticky_o;
    logic [NUM_CH*EW-1:0]   first_ecode_o;
    logic [CW-1:0]          num_errors_o;

    qeciphy_status_tracker_if #(.CH_W(CHW), .STATUS_W(SW), .ECODE_W(EW), .TIME_W(TW)) evt ();
    assign evt.evt_ready_i = ready;

    qeciphy_status_tracker #(
        .NUM_CH(NUM_CH), .STATUS_W(SW), .ECODE_W(EW),
        .FIFO_DEPTH(DEPTH), .TIME_W(TW), .CNT_W(CW)
    ) dut (
        .aclk          (aclk),
        .arst_n        (arst_n),
        .status_i      (status_i),
        .ecode_i       (ecode_i),
        .clr_i         (clr_i),
        .evt           (evt),
        .overflow_o    (overflow_o),
        .err_sticky_o  (err_sticky_o),
        .first_ecode_o (first_ecode_o),
        .num_errors_o  (num_errors_o)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int ch;
        int st;
        int ec;
        int t;
    } ev_t;

    // Reference model: the FIFO is just a queue of expected events.
    ev_t mq [$];
    ev_t m_snap    [NUM_CH];
    bit  m_pend    [NUM_CH];
    int  m_prev_st [NUM_CH];
    int  m_prev_ec [NUM_CH];
    bit  m_sticky  [NUM_CH];
    int  m_first   [NUM_CH];
    bit  m_ovf;
    int  m_nerr;
    int  m_t;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            m_snap[c] = '{0, 0, 0, 0};
            m_pend[c] = 1'b0;
            m_prev_st[c] = 0;
            m_prev_ec[c] = 0;
            m_sticky[c] = 1'b0;
            m_first[c] = 0;
        end
        m_ovf  = 1'b0;
        m_nerr = 0;
        m_t    = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT saw at that edge.
    task automatic model_edge();
        int  sz, g, st, ec;
        bit  pop;
        sz  = mq.size();
        pop = ready && (sz > 0);
        if (clr_i) begin
            mq.delete();
            for (int c = 0; c < NUM_CH; c++) begin
                m_pend[c]    = 1'b0;
                m_sticky[c]  = 1'b0;
                m_first[c]   = 0;
                m_prev_st[c] = int'(status_i[c*SW +: SW]);
                m_prev_ec[c] = int'(ecode_i[c*EW +: EW]);
            end
            m_ovf = 1'b0; m_nerr = 0; m_t = 0;
            return;
        end
        if (pop) void'(mq.pop_front());
        g = -1;
        for (int c = NUM_CH - 1; c >= 0; c--) if (m_pend[c]) g = c;
        if (g >= 0 && (sz < DEPTH || pop)) begin
            mq.push_back(m_snap[g]);
            m_pend[g] = 1'b0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            st = int'(status_i[c*SW +: SW]);
            ec = int'(ecode_i[c*EW +: EW]);
            if (st != m_prev_st[c] || ec != m_prev_ec[c]) begin
                if (m_pend[c]) m_ovf = 1'b1;
                m_pend[c] = 1'b1;
                m_snap[c] = '{c, st, ec, m_t};
            end
            if (m_prev_ec[c] == 0 && ec != 0) begin
                if (!m_sticky[c]) m_first[c] = ec;
                m_sticky[c] = 1'b1;
                if (m_nerr < (1 << CW) - 1) m_nerr++;
            end
            m_prev_st[c] = st;
            m_prev_ec[c] = ec;
        end
        m_t = (m_t + 1) % (1 << TW);
    endtask

    // Monitor: compares DUT state with the model between edges.
    always @(negedge aclk) begin
        if (mon_en) begin
            int exp_t;
            chk("evt_valid", {31'b0, evt.evt_valid_o}, {31'b0, mq.size() > 0});
            if (evt.evt_valid_o && mq.size() > 0) begin
`ifdef QECIPHY_STATUS_TRACKER_TIMESTAMP_EN
                exp_t = mq[0].t;
`else
                exp_t = 0;
`endif
                chk("evt_ch",     32'(evt.evt_ch_o),     32'(mq[0].ch));
                chk("evt_status", 32'(evt.evt_status_o), 32'(mq[0].st));
                chk("evt_ecode",  32'(evt.evt_ecode_o),  32'(mq[0].ec));
                chk("evt_time",   32'(evt.evt_time_o),   32'(exp_t));
            end
            chk("overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
            for (int c = 0; c < NUM_CH; c++) begin
                chk("err_sticky",  {31'b0, err_sticky_o[c]}, {31'b0, m_sticky[c]});
                chk("first_ecode", 32'(first_ecode_o[c*EW +: EW]), 32'(m_first[c]));
            end
            chk("num_errors", 32'(num_errors_o), 32'(m_nerr));
        end
    end

    task automatic cyc(input logic [7:0] st, input logic [7:0] ec, input bit rdy, input bit clr);
        status_i = st;
        ecode_i  = ec;
        ready    = rdy;
        clr_i    = clr;
        @(posedge aclk);
        #1;
        model_edge();
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] cur_st, cur_ec;
        int hold_lo;
        model_reset();
        #2;
        arst_n = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        arst_n = 1'b1;

        repeat (20) cyc(8'h00, 8'h00, 1'b1, 1'b0);
        // Single status change on ch1.
        repeat (6) cyc(8'h30, 8'h00, 1'b1, 1'b0);
        // Both ecodes go 0->5 on one edge.
        repeat (6) cyc(8'h30, 8'h55, 1'b1, 1'b0);
        // Ten distinct ch0 changes with the consumer stalled: fill, pend, coalesce.
        for (int i = 1; i <= 10; i++) cyc({4'h3, 4'(i)}, 8'h55, 1'b0, 1'b0);
        repeat (3) cyc(8'h3a, 8'h55, 1'b0, 1'b0);
        repeat (14) cyc(8'h3a, 8'h55, 1'b1, 1'b0);
        // Clear with FIFO non-empty, then hold inputs static.
        repeat (3) cyc(8'h3b, 8'h55, 1'b0, 1'b0);
        cyc(8'h3b, 8'h55, 1'b0, 1'b1);
        repeat (8) cyc(8'h3b, 8'h55, 1'b1, 1'b0);
        // Ch0 ecode 2 -> 0 -> 7 after the clear.
        repeat (3) cyc(8'h3b, 8'h52, 1'b1, 1'b0);
        repeat (3) cyc(8'h3b, 8'h50, 1'b1, 1'b0);
        repeat (6) cyc(8'h3b, 8'h57, 1'b1, 1'b0);

        cur_st  = 8'h3b;
        cur_ec  = 8'h57;
        hold_lo = 0;
        for (int n = 0; n < 1500; n++) begin
            bit rdy;
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(3) == 0) cur_st[c*SW +: SW] = 4'($urandom);
                if ($urandom_range(5) == 0)
                    cur_ec[c*EW +: EW] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
            end
            if (hold_lo == 0 && $urandom_range(15) == 0) hold_lo = $urandom_range(12);
            if (hold_lo > 0) begin
                rdy = 1'b0;
                hold_lo--;
            end else begin
                rdy = ($urandom_range(3) != 0);
            end
            cyc(cur_st, cur_ec, rdy, $urandom_range(99) == 0);
            if (n == 700) do_reset();
        end
        repeat (20) cyc(cur_st, cur_ec, 1'b1, 1'b0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
